// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus: three producer handshakes plus the broadcast result.
// master = producers/consumers side, slave = arbiter side.
interface cdb_arbiter_if #(
   parameter int ROB_WIDTH = 4
);
   logic                 alu1_valid;
   logic [31:0]          alu1_value;
   logic [ROB_WIDTH-1:0] alu1_tag;
   logic                 alu1_ready;
   logic                 alu2_valid;
   logic [31:0]          alu2_value;
   logic [ROB_WIDTH-1:0] alu2_tag;
   logic                 alu2_ready;
   logic                 load_valid;
   logic [31:0]          load_value;
   logic [ROB_WIDTH-1:0] load_tag;
   logic                 load_ready;
   logic                 cdb_valid;
   logic [31:0]          cdb_value;
   logic [ROB_WIDTH-1:0] cdb_tag;
   logic [1:0]           cdb_src;

   modport master (
      output alu1_valid, alu1_value, alu1_tag,
      output alu2_valid, alu2_value, alu2_tag,
      output load_valid, load_value, load_tag,
      input  alu1_ready, alu2_ready, load_ready,
      input  cdb_valid, cdb_value, cdb_tag, cdb_src
   );

   modport slave (
      input  alu1_valid, alu1_value, alu1_tag,
      input  alu2_valid, alu2_value, alu2_tag,
      input  load_valid, load_value, load_tag,
      output alu1_ready, alu2_ready, load_ready,
      output cdb_valid, cdb_value, cdb_tag, cdb_src
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus scheduler: per-source FIFOs, round-robin grant.
// `define CDB_LOAD_PRIORITY_EN gives LOAD fixed top priority.
module cdb_arbiter #(
   parameter int ROB_WIDTH  = 4,
   parameter int FIFO_WIDTH = 1,
   localparam int FIFO_SIZE = 2**FIFO_WIDTH
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          rdy_in,
   input  logic          clear_signal,
   cdb_arbiter_if.slave  bus
);
   localparam logic [FIFO_WIDTH:0] CNT_FULL =
      (FIFO_WIDTH+1)'(FIFO_SIZE);
   localparam logic [FIFO_WIDTH:0] CNT_ONE =
      (FIFO_WIDTH+1)'(1);
   localparam logic [FIFO_WIDTH-1:0] PTR_ONE =
      FIFO_WIDTH'(1);

   logic [31:0]           q_value [3][FIFO_SIZE];
   logic [ROB_WIDTH-1:0]  q_tag   [3][FIFO_SIZE];
   logic [FIFO_WIDTH-1:0] head [3];
   logic [FIFO_WIDTH-1:0] tail [3];
   logic [FIFO_WIDTH:0]   count [3];
   logic [1:0]            rr_ptr;

   logic [31:0]           in_value [3];
   logic [ROB_WIDTH-1:0]  in_tag   [3];
   logic [2:0]            in_valid;
   logic [2:0]            in_ready;
   logic [2:0]            nonempty;
   logic [2:0]            push;
   logic [2:0]            pop;

   logic                  found;
   logic [1:0]            win;
   logic [1:0]            rr_next;
   logic [1:0]            cand;

   logic                  cdb_valid_q;
   logic [31:0]           cdb_value_q;
   logic [ROB_WIDTH-1:0]  cdb_tag_q;
   logic [1:0]            cdb_src_q;

   function automatic logic [1:0] inc3(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign in_valid = {bus.load_valid,
                      bus.alu2_valid,
                      bus.alu1_valid};
   assign in_value[0] = bus.alu1_value;
   assign in_value[1] = bus.alu2_value;
   assign in_value[2] = bus.load_value;
   assign in_tag[0]   = bus.alu1_tag;
   assign in_tag[1]   = bus.alu2_tag;
   assign in_tag[2]   = bus.load_tag;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         in_ready[i] = (count[i] != CNT_FULL);
         nonempty[i] = (count[i] != '0);
         push[i] = rdy_in & in_valid[i] &
                   in_ready[i] & ~clear_signal;
      end
   end

   assign bus.alu1_ready = in_ready[0];
   assign bus.alu2_ready = in_ready[1];
   assign bus.load_ready = in_ready[2];

`ifdef CDB_LOAD_PRIORITY_EN
   // rr_ptr only toggles between the two ALUs here.
   always_comb begin
      found   = 1'b0;
      win     = 2'd0;
      rr_next = rr_ptr;
      cand    = 2'd0;
      if (nonempty[2]) begin
         found = 1'b1;
         win   = 2'd2;
      end else if (nonempty[rr_ptr[0]]) begin
         found   = 1'b1;
         win     = {1'b0, rr_ptr[0]};
         rr_next = {1'b0, ~rr_ptr[0]};
      end else if (nonempty[~rr_ptr[0]]) begin
         found   = 1'b1;
         win     = {1'b0, ~rr_ptr[0]};
         rr_next = {1'b0, rr_ptr[0]};
      end
   end
`else
   always_comb begin
      found   = 1'b0;
      win     = 2'd0;
      rr_next = rr_ptr;
      cand    = rr_ptr;
      for (int k = 0; k < 3; k++) begin
         if (!found && nonempty[cand]) begin
            found = 1'b1;
            win   = cand;
         end
         cand = inc3(cand);
      end
      if (found) rr_next = inc3(win);
   end
`endif

   assign pop = (rdy_in & ~clear_signal & found) ?
                (3'b001 << win) : 3'b000;

   // Storage needs no reset; pointers decide what is live.
   always_ff @(posedge clk_in) begin
      for (int i = 0; i < 3; i++) begin
         if (push[i]) begin
            q_value[i][tail[i]] <= in_value[i];
            q_tag[i][tail[i]]   <= in_tag[i];
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < 3; i++) begin
            head[i]  <= '0;
            tail[i]  <= '0;
            count[i] <= '0;
         end
         rr_ptr      <= 2'd0;
         cdb_valid_q <= 1'b0;
         cdb_value_q <= '0;
         cdb_tag_q   <= '0;
         cdb_src_q   <= 2'd0;
      end else if (rdy_in) begin
         if (clear_signal) begin
            for (int i = 0; i < 3; i++) begin
               head[i]  <= '0;
               tail[i]  <= '0;
               count[i] <= '0;
            end
            rr_ptr      <= 2'd0;
            cdb_valid_q <= 1'b0;
         end else begin
            for (int i = 0; i < 3; i++) begin
               if (push[i]) tail[i] <= tail[i] + PTR_ONE;
               if (pop[i])  head[i] <= head[i] + PTR_ONE;
               unique case ({push[i], pop[i]})
                  2'b10:   count[i] <= count[i] + CNT_ONE;
                  2'b01:   count[i] <= count[i] - CNT_ONE;
                  default: ;
               endcase
            end
            cdb_valid_q <= found;
            if (found) begin
               cdb_value_q <= q_value[win][head[win]];
               cdb_tag_q   <= q_tag[win][head[win]];
               cdb_src_q   <= win;
               rr_ptr      <= rr_next;
            end
         end
      end
   end

   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_value = cdb_value_q;
   assign bus.cdb_tag   = cdb_tag_q;
   assign bus.cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default build).
module tb_cdb_arbiter;
   logic clk_in;
   logic rst_in;
   logic rdy_in;
   logic clear_signal;

   int n_checks = 0;
   int n_fail   = 0;

   cdb_arbiter_if #(.ROB_WIDTH(4)) bus ();

   cdb_arbiter #(
      .ROB_WIDTH(4),
      .FIFO_WIDTH(1)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .rdy_in(rdy_in),
      .clear_signal(clear_signal),
      .bus(bus)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check_eq(input string tag,
                           input logic [63:0] got,
                           input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alu1_valid = 1'b0;
      bus.alu2_valid = 1'b0;
      bus.load_valid = 1'b0;
   endtask

   task automatic check_cdb(input string tag,
                            input logic v,
                            input logic [31:0] val,
                            input logic [3:0] tg,
                            input logic [1:0] src);
      check_eq({tag, "_v"}, 64'(bus.cdb_valid), 64'(v));
      check_eq({tag, "_val"}, 64'(bus.cdb_value), 64'(val));
      check_eq({tag, "_tag"}, 64'(bus.cdb_tag), 64'(tg));
      check_eq({tag, "_src"}, 64'(bus.cdb_src), 64'(src));
   endtask

   int sent;
   int got;
   logic r2;

   initial begin
      rst_in = 1'b1;
      rdy_in = 1'b1;
      clear_signal = 1'b0;
      idle_inputs();
      bus.alu1_value = '0; bus.alu1_tag = '0;
      bus.alu2_value = '0; bus.alu2_tag = '0;
      bus.load_value = '0; bus.load_tag = '0;

      // reset and idle
      tick();
      tick();
      check_cdb("rst", 1'b0, 32'h0, 4'h0, 2'd0);
      check_eq("rst_rdy", 64'({bus.alu1_ready,
               bus.alu2_ready, bus.load_ready}), 64'h7);
      rst_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("idle_v", 64'(bus.cdb_valid), 64'h0);
      end

      // single path, no bypass
      bus.alu1_valid = 1'b1;
      bus.alu1_value = 32'hAA;
      bus.alu1_tag   = 4'd3;
      tick();
      check_eq("single_nobypass", 64'(bus.cdb_valid), 64'h0);
      idle_inputs();
      tick();
      check_cdb("single", 1'b1, 32'hAA, 4'd3, 2'd0);
      tick();
      check_cdb("single_end", 1'b0, 32'hAA, 4'd3, 2'd0);

      // clear resets rr_ptr, then fairness
      clear_signal = 1'b1;
      tick();
      clear_signal = 1'b0;
      bus.alu1_valid = 1'b1; bus.alu1_value = 32'h11;
      bus.alu1_tag = 4'd1;
      bus.alu2_valid = 1'b1; bus.alu2_value = 32'h22;
      bus.alu2_tag = 4'd2;
      bus.load_valid = 1'b1; bus.load_value = 32'h55;
      bus.load_tag = 4'd5;
      tick();
      idle_inputs();
      check_eq("fair_nobypass", 64'(bus.cdb_valid), 64'h0);
      tick();
      check_cdb("fair0", 1'b1, 32'h11, 4'd1, 2'd0);
      tick();
      check_cdb("fair1", 1'b1, 32'h22, 4'd2, 2'd1);
      tick();
      check_cdb("fair2", 1'b1, 32'h55, 4'd5, 2'd2);
      tick();
      check_eq("fair_end", 64'(bus.cdb_valid), 64'h0);
      // rr_ptr back at 0: ALU1 must beat LOAD
      bus.alu1_valid = 1'b1; bus.alu1_value = 32'h31;
      bus.alu1_tag = 4'd4;
      bus.load_valid = 1'b1; bus.load_value = 32'h35;
      bus.load_tag = 4'd6;
      tick();
      idle_inputs();
      tick();
      check_cdb("rr0_a", 1'b1, 32'h31, 4'd4, 2'd0);
      tick();
      check_cdb("rr0_b", 1'b1, 32'h35, 4'd6, 2'd2);
      tick();

      // backpressure on ALU2 with ALU1/LOAD flooding
      sent = 0;
      got  = 0;
      bus.alu1_value = 32'hA0; bus.alu1_tag = 4'd9;
      bus.load_value = 32'hC0; bus.load_tag = 4'd10;
      for (int cyc = 0; cyc < 60; cyc++) begin
         bus.alu2_valid = (sent < 4);
         bus.alu2_value = 32'hB0 + 32'(sent);
         bus.alu2_tag   = 4'(sent);
         bus.alu1_valid = (sent < 4);
         bus.load_valid = (sent < 4);
         r2 = bus.alu2_ready;
         tick();
         if (bus.alu2_valid && r2) sent++;
         if (cyc == 1)
            check_eq("bp_full", 64'(bus.alu2_ready), 64'h0);
         if (bus.cdb_valid && bus.cdb_src == 2'd1) begin
            check_eq("bp_order", 64'(bus.cdb_value),
                     64'(32'hB0 + 32'(got)));
            got++;
         end
      end
      idle_inputs();
      check_eq("bp_sent", 64'(sent), 64'd4);
      check_eq("bp_got", 64'(got), 64'd4);
      check_eq("bp_drained", 64'(bus.cdb_valid), 64'h0);

      // flush with pending entries
      bus.alu1_valid = 1'b1;
      bus.alu2_valid = 1'b1;
      bus.load_valid = 1'b1;
      tick();
      tick();
      idle_inputs();
      clear_signal = 1'b1;
      bus.alu1_valid = 1'b1;
      bus.alu1_value = 32'hDEAD;
      tick();
      clear_signal = 1'b0;
      idle_inputs();
      check_eq("flush_v", 64'(bus.cdb_valid), 64'h0);
      check_eq("flush_rdy", 64'({bus.alu1_ready,
               bus.alu2_ready, bus.load_ready}), 64'h7);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("flush_idle", 64'(bus.cdb_valid), 64'h0);
      end

      // pause holding a tag-7 broadcast
      bus.alu1_valid = 1'b1; bus.alu1_value = 32'h77;
      bus.alu1_tag = 4'd7;
      bus.alu2_valid = 1'b1; bus.alu2_value = 32'h88;
      bus.alu2_tag = 4'd8;
      tick();
      idle_inputs();
      tick();
      check_cdb("pre_pause", 1'b1, 32'h77, 4'd7, 2'd0);
      rdy_in = 1'b0;
      bus.alu1_valid = 1'b1; bus.alu1_value = 32'h99;
      bus.alu1_tag = 4'd9;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_cdb("pause", 1'b1, 32'h77, 4'd7, 2'd0);
      end
      rdy_in = 1'b1;
      idle_inputs();
      tick();
      check_cdb("resume", 1'b1, 32'h88, 4'd8, 2'd1);
      tick();
      check_eq("resume_end", 64'(bus.cdb_valid), 64'h0);
      tick();
      check_eq("no_paused_push", 64'(bus.cdb_valid), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Common-data-bus (CDB) scheduler. Shares one result-broadcast bus between three producers: ALU1, ALU2 and the LSB load path.
- Each producer gets a small in-order queue. One result per cycle is granted round-robin and broadcast, registered, to the ROB, the reservation stations and the LSB.
- A mispredict clear flushes all pending results.

Parameters:
ROB_WIDTH, 4, width of the ROB tag carried with each result
FIFO_WIDTH, 1, log2 of per-source queue depth
FIFO_SIZE, 2**FIFO_WIDTH, entries per source queue

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global pause; low = hold all state and outputs
clear_signal  input  1  mispredict flush from ROB
alu1_valid  input  1  ALU1 result offered
alu1_value  input  32  ALU1 result
alu1_tag  input  ROB_WIDTH  ALU1 ROB tag
alu1_ready  output  1  ALU1 queue can accept (combinational)
alu2_valid / alu2_value / alu2_tag / alu2_ready  as ALU1, for ALU2
load_valid / load_value / load_tag / load_ready  as ALU1, for the LSB load path
cdb_valid  output  1  broadcast valid, registered
cdb_value  output  32  broadcast value
cdb_tag  output  ROB_WIDTH  broadcast ROB tag
cdb_src  output  2  granted source: 0=ALU1, 1=ALU2, 2=LOAD

Behaviour:
- Reset (rst_in=1 at a clock edge):
  - All queues emptied; rr_ptr=0.
  - cdb_valid=0, cdb_value=0, cdb_tag=0, cdb_src=0.
- Pause: rdy_in=0 → no push, no pop, rr_ptr and all cdb_* outputs hold.
- Queue ready: X_ready = (count_X != FIFO_SIZE), combinational from registered count only. A full queue does not accept even when it is popped in the same cycle.
- Push: accepted at an edge when rdy_in & X_valid & X_ready & ~clear_signal.
- Queue ordering and pointers:
  - Each queue is a circular buffer with head/tail pointers of FIFO_WIDTH bits that wrap naturally.
  - count has FIFO_WIDTH+1 bits.
  - Results within one source leave in arrival order.
- Grant: evaluated every unpaused cycle over the non-empty queues, using registered state only.
  - Priority order is rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - The first non-empty queue wins. Its head entry is popped and loaded into cdb_value/cdb_tag/cdb_src, and cdb_valid<=1.
  - rr_ptr <= (winner+1) mod 3.
  - If no queue is non-empty: cdb_valid<=0, rr_ptr unchanged, cdb_value/tag/src hold.
- Latency: a result pushed at edge t is granted no earlier than edge t+1 (cdb_valid visible after t+1). No same-cycle bypass from input to CDB.
- Push and pop on the same queue in the same cycle: both take effect; count unchanged.
- cdb_valid pulses for exactly one unpaused cycle per granted result. Consumers sample only when rdy_in=1.
- Clear (clear_signal=1 & rdy_in=1):
  - All queues emptied; inputs offered that cycle are dropped.
  - cdb_valid<=0; rr_ptr<=0.
  - Takes precedence over grant and push.
- rst_in takes precedence over clear_signal and rdy_in.

Optional Feature:
CDB_LOAD_PRIORITY_EN
- Defined: LOAD is fixed highest priority. Whenever the LOAD queue is non-empty it wins. Otherwise ALU1/ALU2 are arbitrated round-robin between themselves, with rr_ptr restricted to {0,1} and updated only on ALU grants.
- Undefined: the pure 3-way round-robin described above.

Test Plan:
- Reset then idle: rst_in=1 for 2 cycles, then no valids for 5 cycles → cdb_valid=0 throughout; all *_ready=1.
- Single path: alu1 pushes (value=0x0000_00AA, tag=3) at edge t → at edge t+1 cdb_valid=1, cdb_value=0xAA, cdb_tag=3, cdb_src=0; at t+2 cdb_valid=0.
- Fairness: all three sources push one result each in the same cycle (tags 1,2,5) → next three cycles broadcast src 0,1,2 in that order with tags 1,2,5; rr_ptr returns to 0.
- Backpressure: ALU2 offers 4 results back-to-back while ALU1 and LOAD queues are kept full → alu2_ready drops after 2 accepted (FIFO_SIZE=2). All 4 values eventually broadcast in order with no loss or duplication.
- Flush: 2 entries queued in each source, clear_signal=1 for one cycle with alu1_valid=1 → next cycle cdb_valid=0, all queues empty, the alu1 input that cycle is not broadcast.
- Pause: hold rdy_in=0 for 3 cycles while cdb_valid=1 (tag=7) → cdb outputs held at tag 7, no pushes accepted. After rdy_in=1 the next queued result is broadcast one cycle later.
